// File: rtl/mult_operand_feeder.sv
// Operand-pair FIFO and one-at-a-time sequencer in front of the 32x32 multiplier.
// Optional macro MULT_FEEDER_ZERO_BYPASS_EN: zero-operand pairs complete without a multiplier start.
`timescale 1ns/1ps
module mult_operand_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int DW         = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW-1:0]                 in_a,
  input  logic [DW-1:0]                 in_b,
  output logic                          mul_start,
  output logic [DW-1:0]                 mul_a,
  output logic [DW-1:0]                 mul_b,
  input  logic                          mul_busy,
  input  logic [2*DW-1:0]               mul_product,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*DW-1:0]               out_product,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_OUTPUT    = 3'd4
  } state_t;

  logic [DW-1:0]   mem_a_r [FIFO_DEPTH];
  logic [DW-1:0]   mem_b_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_next_s;
  logic            in_ready_r;
  state_t          state_r;
  logic            wait_cnt_r;
  logic            mul_start_r, out_valid_r;
  logic [DW-1:0]   mul_a_r, mul_b_r;
  logic [2*DW-1:0] out_product_r;
  logic            push_s, pop_s, empty_s, zero_pair_s;
  logic [DW-1:0]   head_a_s, head_b_s;

  assign head_a_s = mem_a_r[rd_ptr_r];
  assign head_b_s = mem_b_r[rd_ptr_r];

`ifdef MULT_FEEDER_ZERO_BYPASS_EN
  assign zero_pair_s = (head_a_s == {DW{1'b0}}) || (head_b_s == {DW{1'b0}});
`else
  assign zero_pair_s = 1'b0;
`endif

  // Handshake qualifiers and next FIFO occupancy; the FSM pops only when it can launch.
  always_comb begin
    push_s  = in_valid & in_ready_r;
    empty_s = (count_r == {CW{1'b0}});
    pop_s   = 1'b0;
    if (!empty_s) begin
      case (state_r)
        S_IDLE:   pop_s = !out_valid_r;
        S_OUTPUT: pop_s = out_ready;
        default:  pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end
    count_next_s = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
  end

  // Operand FIFO storage, pointers and registered ready (a full FIFO never sees a push).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_a_r[i] <= {DW{1'b0}};
        mem_b_r[i] <= {DW{1'b0}};
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_a_r[wr_ptr_r] <= in_a;
        mem_b_r[wr_ptr_r] <= in_b;
        wr_ptr_r          <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s != CW'(FIFO_DEPTH));
    end
  end

  // Sequencer: launch, wait for the multiplier, present the result, chain the next pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      wait_cnt_r    <= 1'b0;
      mul_start_r   <= 1'b0;
      mul_a_r       <= {DW{1'b0}};
      mul_b_r       <= {DW{1'b0}};
      out_valid_r   <= 1'b0;
      out_product_r <= {(2*DW){1'b0}};
    end else begin
      case (state_r)
        S_IDLE, S_OUTPUT: begin
          if ((state_r == S_OUTPUT) && out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end
          if (pop_s) begin
            mul_a_r <= head_a_s;
            mul_b_r <= head_b_s;
            if (zero_pair_s) begin
              out_product_r <= {(2*DW){1'b0}};
              out_valid_r   <= 1'b1;
              state_r       <= S_OUTPUT;
            end else begin
              mul_start_r <= 1'b1;
              state_r     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          mul_start_r <= 1'b0;
          wait_cnt_r  <= 1'b0;
          state_r     <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (mul_busy) begin
            state_r <= S_WAIT_DONE;
          end else if (wait_cnt_r) begin
            // Multiplier finished without ever raising busy.
            out_product_r <= mul_product;
            out_valid_r   <= 1'b1;
            state_r       <= S_OUTPUT;
          end else begin
            wait_cnt_r <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!mul_busy) begin
            out_product_r <= mul_product;
            out_valid_r   <= 1'b1;
            state_r       <= S_OUTPUT;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          mul_start_r <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign mul_start   = mul_start_r;
  assign mul_a       = mul_a_r;
  assign mul_b       = mul_b_r;
  assign out_valid   = out_valid_r;
  assign out_product = out_product_r;
  assign fifo_count  = count_r;

endmodule

// File: doc/mult_operand_feeder.md
Name: mult_operand_feeder

Overview:
- Upstream sequencer for the 32x32 fast multiplier.
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues one-cycle start pulses to the multiplier, waits for it to complete, and returns each 64-bit product over a valid/ready output stream in issue order.
- Decouples producers from the multiplier's variable busy time.

Parameters:
- FIFO_DEPTH, 4, operand-pair FIFO entries; power of two, 2..16.
- DW, 32, operand width; product width is 2*DW.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset; 0 = reset asserted.
- in_valid  in  1  operand pair present.
- in_ready  out  1  FIFO can accept a pair.
- in_a  in  DW  operand A.
- in_b  in  DW  operand B.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  DW  operand A to the multiplier, held stable from start until completion.
- mul_b  out  DW  operand B to the multiplier, held stable from start until completion.
- mul_busy  in  1  multiplier busy.
- mul_product  in  2*DW  multiplier result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2*DW  result.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of pairs buffered.

Behaviour:
- Reset (reset=0, async): FIFO empty, fifo_count=0, in_ready=0 while reset is held and 1 from the first clock after release. mul_start=0, mul_a=0, mul_b=0, out_valid=0, out_product=0, FSM=IDLE.
- Input handshake: a transfer occurs when in_valid&in_ready at a rising edge.
  - in_ready = !full; it is registered and does not depend on in_valid.
  - Push and pop in the same cycle on a full FIFO: only the pop is allowed; in_ready is already 0.
  - Push and pop in the same cycle otherwise: count unchanged, pointers each advance, wrapping at FIFO_DEPTH.
- FIFO: registered storage; data is visible to the FSM the cycle after the push. Minimum input-to-start latency is 2 cycles.
- FSM states:
  - IDLE: if the FIFO is non-empty and out_valid=0, pop the head, load mul_a/mul_b, go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: wait for mul_busy=1, then go to WAIT_DONE.
    - If mul_busy is still 0 after 2 cycles in this state, the multiplier completed without asserting busy: capture mul_product and go to OUTPUT.
  - WAIT_DONE: on the first cycle with mul_busy=0, capture mul_product into out_product, set out_valid=1, go to OUTPUT.
  - OUTPUT: hold out_valid and out_product stable until out_ready=1, then clear out_valid and return to IDLE.
    - If the FIFO is non-empty at that edge, pop the next pair and go directly to ISSUE (back-to-back).
- Only one multiply is outstanding at a time; there is no reordering.
- mul_a/mul_b keep their last values in IDLE.
- Products are unsigned, full 2*DW width, with no truncation.
- out_ready asserted while out_valid=0 is ignored.
- A reset assertion mid-operation aborts immediately. The FIFO contents and any in-flight result are discarded. The multiplier shares the same reset.

Optional Feature:
- Macro MULT_FEEDER_ZERO_BYPASS_EN.
- Defined: in IDLE, when the popped pair has in_a==0 or in_b==0, skip ISSUE/WAIT.
  - out_product=0 and out_valid=1 are registered on the next edge; the FSM goes to OUTPUT.
  - mul_start is never pulsed for that pair. Ordering with other pairs is preserved.
- Not defined: every pair, including zero operands, goes through the multiplier.

Test Plan:
- Reset: hold reset=0 for 4 cycles with in_valid=1 -> in_ready=0, out_valid=0, mul_start=0, fifo_count=0. Release -> in_ready=1 next cycle.
- Single op: push a=32'hFFFF, b=32'hFFFF -> exactly one mul_start pulse with mul_a=mul_b=32'hFFFF. After busy falls, out_valid=1 with out_product=64'hFFFE0001.
- Back-to-back with stall:
  - Push 32'h1FFFF x 32'h1FFFF, then 3 x 5, with out_ready=0 for 10 cycles -> first result 64'h3FFFC0001 held stable; no second mul_start.
  - Raise out_ready -> second start the next cycle; result 64'd15.
- FIFO full: push FIFO_DEPTH+2 pairs while out_ready=0 -> the FIFO holds FIFO_DEPTH pairs and one pair sits in the FSM. in_ready=0 exactly when fifo_count=FIFO_DEPTH; no pair is lost or duplicated; results emerge in order.
- Mid-operation reset: assert reset during WAIT_DONE -> out_valid=0 and fifo_count=0 immediately. After release, a new push 2 x 7 yields 64'd14.
- Zero bypass (macro defined): push 0 x 32'hFFFFFFFF -> out_product=0, no mul_start pulse. Without the macro -> mul_start pulses and the result is still 0.
